// File: rtl/axi4_lite_queued_master.sv
// AXI4-Lite master with an in-order command queue.
// Commands are buffered in a small FIFO and executed one at a time; each
// finished transaction is presented on the rsp_* interface until consumed.
// Non-OKAY slave responses are tallied in a saturating error counter.
module axi4_lite_queued_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int ERR_CNT_W  = 16,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_W-1:0]     cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // status
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_count,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic [2:0]            M_AWPROT,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_W-1:0]     M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [2:0]            M_ARPROT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int IDX_W = $clog2(CMD_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // command FIFO storage (data only, never reset)
  logic                  fifo_write [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
  logic [STRB_W-1:0]     fifo_wstrb [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push, pop, accept_en;

  // active command and captured response
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [STRB_W-1:0]     cur_wstrb;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  // control state
  state_t               state;
  logic                 aw_valid, w_valid, ar_valid, bready, rready, rsp_valid_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 aw_fin, w_fin, b_hs, r_hs;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  // wrap bits differ with equal indices means the writer lapped the reader
  assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr == rd_ptr);

  // accept_en keeps cmd_ready low through reset and its release cycle
  assign cmd_ready = accept_en && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;

  // a channel is finished once its valid has dropped or it handshakes now
  assign aw_fin = !aw_valid || M_AWREADY;
  assign w_fin  = !w_valid  || M_WREADY;
  assign b_hs   = (state == WR_RESP) && M_BVALID;
  assign r_hs   = (state == RD_DATA) && M_RVALID;

  // FIFO pointers and the post-reset accept enable
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      accept_en <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO entry write on push
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_write[wr_idx] <= cmd_write;
      fifo_addr[wr_idx]  <= cmd_addr;
      fifo_wdata[wr_idx] <= cmd_wdata;
      fifo_wstrb[wr_idx] <= cmd_wstrb;
    end
  end

  // Load the popped command and capture B/R payloads into the response buffer
  always_ff @(posedge ACLK) begin
    if (pop) begin
      cur_addr  <= fifo_addr[rd_idx];
      cur_wdata <= fifo_wdata[rd_idx];
      cur_wstrb <= fifo_wstrb[rd_idx];
    end
    if (b_hs) begin
      rsp_write_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= M_BRESP;
    end
    if (r_hs) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= M_RDATA;
      rsp_resp_q  <= M_RRESP;
    end
  end

  // Transaction FSM with registered handshake outputs and error counter
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= IDLE;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      ar_valid    <= 1'b0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (fifo_write[rd_idx]) begin
              state    <= WR;
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              ar_valid <= 1'b1;
            end
          end
        end
        WR: begin
          if (M_AWREADY) aw_valid <= 1'b0;
          if (M_WREADY)  w_valid  <= 1'b0;
          if (aw_fin && w_fin) begin
            state  <= WR_RESP;
            bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (M_BVALID) begin
            state       <= RSP;
            bready      <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (M_BRESP != 2'b00) err_q <= sat_inc(err_q);
          end
        end
        RD_ADDR: begin
          if (M_ARREADY) begin
            state    <= RD_DATA;
            ar_valid <= 1'b0;
            rready   <= 1'b1;
          end
        end
        RD_DATA: begin
          if (M_RVALID) begin
            state       <= RSP;
            rready      <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (M_RRESP != 2'b00) err_q <= sat_inc(err_q);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // payloads are zero whenever their qualifying valid is low
  assign M_AWVALID = aw_valid;
  assign M_AWADDR  = aw_valid ? cur_addr : '0;
  assign M_AWPROT  = 3'b000;
  assign M_WVALID  = w_valid;
  assign M_WDATA   = w_valid ? cur_wdata : '0;
  assign M_WSTRB   = w_valid ? cur_wstrb : '0;
  assign M_BREADY  = bready;
  assign M_ARVALID = ar_valid;
  assign M_ARADDR  = ar_valid ? cur_addr : '0;
  assign M_ARPROT  = 3'b000;
  assign M_RREADY  = rready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_valid_q && rsp_write_q;
  assign rsp_rdata = rsp_valid_q ? rsp_rdata_q : '0;
  assign rsp_resp  = rsp_valid_q ? rsp_resp_q  : 2'b00;

  assign busy      = !empty || (state != IDLE);
  assign err_count = err_q;

endmodule

// File: tb/tb_axi4_lite_queued_master.sv
// Directed bench for axi4_lite_queued_master: the slave side is driven by
// hand from the main process; inputs change and outputs are sampled on the
// falling clock edge.
module tb_axi4_lite_queued_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 2;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [EW-1:0] err_count;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic [2:0]    M_AWPROT, M_ARPROT;
  logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [DW-1:0] M_WDATA, M_RDATA;
  logic [SW-1:0] M_WSTRB;
  logic [1:0]    M_BRESP, M_RRESP;
  logic          M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_queued_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .ERR_CNT_W(EW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .err_count(err_count),
    .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  // offer one command and hold it until the DUT takes it
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    int k;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    check_val("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  // accept AW and W together, check payload, return one B
  task automatic serve_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input logic [1:0] resp);
    int k;
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    k = 0;
    while (!M_AWVALID && k < 100) begin tick(); k++; end
    check_val("sw_awvalid", M_AWVALID, 1);
    check_val("sw_wvalid", M_WVALID, 1);
    check_val("sw_awaddr", M_AWADDR, a);
    check_val("sw_wdata", M_WDATA, d);
    check_val("sw_wstrb", M_WSTRB, s);
    tick();
    M_AWREADY = 1'b0; M_WREADY = 1'b0;
    check_val("sw_bready", M_BREADY, 1);
    M_BVALID = 1'b1; M_BRESP = resp;
    tick();
    M_BVALID = 1'b0; M_BRESP = 2'b00;
  endtask

  // accept AR, check address, return one R beat
  task automatic serve_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] resp);
    int k;
    M_ARREADY = 1'b1;
    k = 0;
    while (!M_ARVALID && k < 100) begin tick(); k++; end
    check_val("sr_arvalid", M_ARVALID, 1);
    check_val("sr_araddr", M_ARADDR, a);
    tick();
    M_ARREADY = 1'b0;
    check_val("sr_rready", M_RREADY, 1);
    M_RVALID = 1'b1; M_RDATA = d; M_RRESP = resp;
    tick();
    M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
  endtask

  // wait for a response, check it, consume it
  task automatic pop_rsp(input logic w, input logic [DW-1:0] d, input logic [1:0] resp);
    int k;
    k = 0;
    while (!rsp_valid && k < 100) begin tick(); k++; end
    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_write", rsp_write, w);
    check_val("rsp_rdata", rsp_rdata, d);
    check_val("rsp_resp", rsp_resp, resp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] resp);
    push(1'b1, a, d, s);
    serve_write(a, d, s, resp);
    pop_rsp(1'b1, '0, resp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
    push(1'b0, a, '0, '0);
    serve_read(a, d, resp);
    pop_rsp(1'b0, d, resp);
  endtask

  // never let a broken DUT hang the run
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;

    // reset state
    repeat (3) tick();
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_awvalid", M_AWVALID, 0);
    check_val("rst_wvalid", M_WVALID, 0);
    check_val("rst_arvalid", M_ARVALID, 0);
    check_val("rst_bready", M_BREADY, 0);
    check_val("rst_rready", M_RREADY, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_err", err_count, 0);
    ARESETN = 1'b1;
    tick();
    check_val("rel_cmd_ready", cmd_ready, 1);

    // single write, slave always ready: AWVALID is high at edge N+2
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
    cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'hF;
    tick();                                   // edge N accepted the command
    cmd_valid = 1'b0;
    check_val("w1_awvalid_n1", M_AWVALID, 0);
    check_val("w1_busy", busy, 1);
    tick();                                   // edge N+1 popped it
    check_val("w1_awvalid_n2", M_AWVALID, 1);
    check_val("w1_wvalid_n2", M_WVALID, 1);
    check_val("w1_awaddr", M_AWADDR, 32'h10);
    check_val("w1_wdata", M_WDATA, 32'hA5A5_0001);
    check_val("w1_wstrb", M_WSTRB, 4'hF);
    check_val("w1_awprot", M_AWPROT, 0);
    check_val("w1_bready_early", M_BREADY, 0);
    tick();                                   // edge N+2 handshakes both
    check_val("w1_awvalid_done", M_AWVALID, 0);
    check_val("w1_wvalid_done", M_WVALID, 0);
    check_val("w1_awaddr_zero", M_AWADDR, 0);
    check_val("w1_bready", M_BREADY, 1);
    M_AWREADY = 1'b0; M_WREADY = 1'b0;
    M_BVALID = 1'b1; M_BRESP = 2'b00;
    tick();
    M_BVALID = 1'b0;
    check_val("w1_bready_rsp", M_BREADY, 0);
    pop_rsp(1'b1, 32'h0, 2'b00);
    check_val("w1_rsp_gone", rsp_valid, 0);
    check_val("w1_idle", busy, 0);
    check_val("w1_err", err_count, 0);

    // read with ARREADY held off: ARVALID must stay up for 4 edges
    push(1'b0, 32'h14, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("r1_arvalid_hold", M_ARVALID, 1);
      check_val("r1_araddr_hold", M_ARADDR, 32'h14);
      check_val("r1_rready_low", M_RREADY, 0);
    end
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    check_val("r1_arvalid_done", M_ARVALID, 0);
    check_val("r1_rready", M_RREADY, 1);
    M_RVALID = 1'b1; M_RDATA = 32'hDEAD_BEEF; M_RRESP = 2'b00;
    tick();
    M_RVALID = 1'b0; M_RDATA = '0;
    pop_rsp(1'b0, 32'hDEAD_BEEF, 2'b00);

    // W accepted two cycles before AW; B answered SLVERR and held extra cycle
    M_WREADY = 1'b1;
    push(1'b1, 32'h18, 32'h0BAD_F00D, 4'h5);
    tick();
    check_val("w2_awvalid_a", M_AWVALID, 1);
    check_val("w2_wvalid_a", M_WVALID, 1);
    tick();                                   // W handshake happened
    check_val("w2_wvalid_drop", M_WVALID, 0);
    check_val("w2_wdata_zero", M_WDATA, 0);
    check_val("w2_awvalid_b", M_AWVALID, 1);
    check_val("w2_bready_wait", M_BREADY, 0);
    tick();
    check_val("w2_awvalid_c", M_AWVALID, 1);
    check_val("w2_awaddr_c", M_AWADDR, 32'h18);
    M_WREADY = 1'b0; M_AWREADY = 1'b1;
    tick();                                   // AW handshake happened
    M_AWREADY = 1'b0;
    check_val("w2_awvalid_drop", M_AWVALID, 0);
    check_val("w2_bready", M_BREADY, 1);
    M_BVALID = 1'b1; M_BRESP = 2'b10;
    tick();
    check_val("w2_rsp_valid", rsp_valid, 1);
    check_val("w2_bready_off", M_BREADY, 0);
    check_val("w2_err_one", err_count, 1);
    tick();                                   // BVALID still up: must be ignored
    check_val("w2_bready_still_off", M_BREADY, 0);
    check_val("w2_err_single_b", err_count, 1);
    M_BVALID = 1'b0; M_BRESP = 2'b00;

    // response left pending: four commands fill the queue, fifth waits
    push(1'b1, 32'h100, 32'h1111_1111, 4'h3);
    push(1'b0, 32'h104, '0, '0);
    push(1'b1, 32'h108, 32'h0000_0033, 4'h1);
    push(1'b0, 32'h10C, '0, '0);
    check_val("q_full_ready", cmd_ready, 0);
    check_val("q_full_busy", busy, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h110;
    cmd_wdata = 32'h0000_0055; cmd_wstrb = 4'hF;
    tick();
    check_val("q_still_full", cmd_ready, 0);
    pop_rsp(1'b1, 32'h0, 2'b10);              // releases the FSM to IDLE
    check_val("q_idle_full", cmd_ready, 0);
    tick();                                   // head popped
    check_val("q_ready_after_pop", cmd_ready, 1);
    tick();                                   // fifth command accepted
    cmd_valid = 1'b0;
    check_val("q_full_again", cmd_ready, 0);
    serve_write(32'h100, 32'h1111_1111, 4'h3, 2'b00);
    pop_rsp(1'b1, 32'h0, 2'b00);
    serve_read(32'h104, 32'h2222_0000, 2'b00);
    pop_rsp(1'b0, 32'h2222_0000, 2'b00);
    serve_write(32'h108, 32'h0000_0033, 4'h1, 2'b00);
    pop_rsp(1'b1, 32'h0, 2'b00);
    serve_read(32'h10C, 32'h4444_4444, 2'b00);
    pop_rsp(1'b0, 32'h4444_4444, 2'b00);
    serve_write(32'h110, 32'h0000_0055, 4'hF, 2'b00);
    pop_rsp(1'b1, 32'h0, 2'b00);
    check_val("q_err_unchanged", err_count, 1);
    check_val("q_drained", busy, 0);

    // error counter: SLVERR read, OKAY write, then saturation at 3
    do_read(32'h200, 32'h0000_00EE, 2'b10);
    do_write(32'h204, 32'h0000_0001, 4'hF, 2'b00);
    check_val("err_two", err_count, 2);
    do_write(32'h208, 32'h0000_0002, 4'hF, 2'b11);
    check_val("err_three", err_count, 3);
    do_read(32'h20C, 32'h0000_1234, 2'b10);
    check_val("err_saturated", err_count, 3);

    // reset while waiting for B with a second command still queued
    push(1'b1, 32'h300, 32'h0000_0300, 4'hF);
    push(1'b0, 32'h304, '0, '0);
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    tick();
    M_AWREADY = 1'b0; M_WREADY = 1'b0;
    check_val("mr_in_wr_resp", M_BREADY, 1);
    ARESETN = 1'b0;
    M_BVALID = 1'b1; M_BRESP = 2'b10;
    tick();
    check_val("mr_awvalid", M_AWVALID, 0);
    check_val("mr_wvalid", M_WVALID, 0);
    check_val("mr_arvalid", M_ARVALID, 0);
    check_val("mr_bready", M_BREADY, 0);
    check_val("mr_rready", M_RREADY, 0);
    check_val("mr_rsp_valid", rsp_valid, 0);
    check_val("mr_busy", busy, 0);
    check_val("mr_cmd_ready", cmd_ready, 0);
    check_val("mr_err", err_count, 0);
    ARESETN = 1'b1;
    M_BVALID = 1'b0; M_BRESP = 2'b00;
    tick();
    check_val("mr_rel_ready", cmd_ready, 1);
    check_val("mr_rel_busy", busy, 0);
    tick();
    check_val("mr_fifo_empty", busy, 0);
    check_val("mr_no_arvalid", M_ARVALID, 0);
    do_read(32'h400, 32'hCAFE_F00D, 2'b00);
    check_val("mr_err_after", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
